// File: rtl/timed_channel_scanner.sv
// rtl/timed_channel_scanner.sv - N-channel timed round-robin scanner with hold, manual advance and enable mask.
// Optional forced select is compiled in with SCAN_FORCE_SEL_EN.
module timed_channel_scanner #(
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int DATA_W      = 16,
  parameter int N_CH        = 4,
  parameter int DWELL_MS    = 1000,
  localparam int IDX_W      = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_CH*DATA_W-1:0]   data_in,
  input  logic [N_CH-1:0]          ch_en,
  input  logic                     hold,
  input  logic                     next,
  output logic [DATA_W-1:0]        data_out,
  output logic [IDX_W-1:0]         sel_idx,
  output logic                     sel_valid,
  output logic                     switch_pulse
`ifdef SCAN_FORCE_SEL_EN
  ,
  input  logic                     force_en,
  input  logic [IDX_W-1:0]         force_idx
`endif
);

  localparam int DWELL_CYC = CLK_FREQ_HZ / 1000 * DWELL_MS;
  localparam int CNT_W     = $clog2(DWELL_CYC + 1);

  logic [IDX_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  logic [IDX_W-1:0] nxt_idx;
  logic             found;
  logic             terminal;
  logic             advance;
  logic             mask_empty;
  int               idx;

  assign mask_empty = (ch_en == '0);
  assign terminal   = (cnt_q == CNT_W'(DWELL_CYC - 1)) && !hold;
  assign advance    = terminal || next || !ch_en[sel_q];

  // Search starts one past the current channel and visits the current one last.
  always_comb begin
    nxt_idx = sel_q;
    found   = 1'b0;
    idx     = 0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = int'(sel_q) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!found && ch_en[idx]) begin
        nxt_idx = IDX_W'(idx);
        found   = 1'b1;
      end
    end
  end

`ifdef SCAN_FORCE_SEL_EN
  logic [IDX_W-1:0] force_sat;
  assign force_sat = (force_idx > IDX_W'(N_CH - 1)) ? IDX_W'(N_CH - 1) : force_idx;
`endif

  always_comb begin
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
`ifdef SCAN_FORCE_SEL_EN
    if (force_en) begin
      sel_d   = force_sat;
      cnt_d   = '0;
      pulse_d = (force_sat != sel_q);
    end else
`endif
    if (mask_empty) begin
      cnt_d = '0;
    end else if (advance) begin
      sel_d   = nxt_idx;
      cnt_d   = '0;
      pulse_d = 1'b1;
    end else if (!hold) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q   <= '0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

`ifdef SCAN_FORCE_SEL_EN
  assign sel_valid = force_en || !mask_empty;
`else
  assign sel_valid = !mask_empty;
`endif

  always_comb begin
    data_out = '0;
    if (sel_valid) begin
      for (int k = 0; k < N_CH; k++) begin
        if (sel_q == IDX_W'(k)) data_out = data_in[k*DATA_W +: DATA_W];
      end
    end
  end

  assign sel_idx      = sel_q;
  assign switch_pulse = pulse_q;

endmodule

// File: tb/tb_timed_channel_scanner.sv
// tb/tb_timed_channel_scanner.sv - table-driven bench for timed_channel_scanner (DWELL_CYC=8, N_CH=4).
// Forced-select sequence runs only when SCAN_FORCE_SEL_EN is defined.
module tb_timed_channel_scanner;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] data_in;
  logic [3:0]  ch_en;
  logic        hold;
  logic        next;
  logic [15:0] data_out;
  logic [1:0]  sel_idx;
  logic        sel_valid;
  logic        switch_pulse;
`ifdef SCAN_FORCE_SEL_EN
  logic        force_en;
  logic [1:0]  force_idx;
`endif

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  timed_channel_scanner #(
    .CLK_FREQ_HZ(8000),
    .DATA_W(16),
    .N_CH(4),
    .DWELL_MS(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .data_in(data_in),
    .ch_en(ch_en),
    .hold(hold),
    .next(next),
    .data_out(data_out),
    .sel_idx(sel_idx),
    .sel_valid(sel_valid),
    .switch_pulse(switch_pulse)
`ifdef SCAN_FORCE_SEL_EN
    ,
    .force_en(force_en),
    .force_idx(force_idx)
`endif
  );

  typedef struct {
    string       name;
    logic [3:0]  en;
    logic        hold;
    logic        next;
    int          cyc;
    logic [1:0]  idx;
    logic        valid;
    logic [15:0] data;
    int          npulse;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input string name, input logic [3:0] en, input logic h, input logic n,
                              input int cyc, input logic [1:0] idx, input logic valid,
                              input logic [15:0] data, input int npulse);
    vec_t v;
    v.name = name; v.en = en; v.hold = h; v.next = n; v.cyc = cyc;
    v.idx = idx; v.valid = valid; v.data = data; v.npulse = npulse;
    vt.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run(input int n);
    pulses = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (switch_pulse) pulses++;
    end
  endtask

  task automatic expect_state(input string name, input logic [1:0] idx, input logic valid,
                              input logic [15:0] data, input int npulse);
    chk({name, ".idx"}, 32'(sel_idx), 32'(idx));
    chk({name, ".valid"}, 32'(sel_valid), 32'(valid));
    chk({name, ".data"}, 32'(data_out), 32'(data));
    chk({name, ".pulses"}, 32'(pulses), 32'(npulse));
  endtask

  initial begin
    // name, ch_en, hold, next, cycles, idx, valid, data, pulses in window
    add("scan0_cnt7",   4'b1111, 0, 0, 7, 2'd0, 1, 16'hA000, 0);
    add("scan_to1",     4'b1111, 0, 0, 1, 2'd1, 1, 16'hA001, 1);
    add("scan1_cnt1",   4'b1111, 0, 0, 1, 2'd1, 1, 16'hA001, 0);
    add("scan_to2",     4'b1111, 0, 0, 7, 2'd2, 1, 16'hA002, 1);
    add("scan_to3",     4'b1111, 0, 0, 8, 2'd3, 1, 16'hA003, 1);
    add("scan_wrap0",   4'b1111, 0, 0, 8, 2'd0, 1, 16'hA000, 1);
    add("m0101_to2",    4'b0101, 0, 0, 8, 2'd2, 1, 16'hA002, 1);
    add("m0101_to0",    4'b0101, 0, 0, 8, 2'd0, 1, 16'hA000, 1);
    add("m0101_to2b",   4'b0101, 0, 0, 8, 2'd2, 1, 16'hA002, 1);
    add("m0101_cnt3",   4'b0101, 0, 0, 3, 2'd2, 1, 16'hA002, 0);
    add("disable_cur",  4'b0001, 0, 0, 1, 2'd0, 1, 16'hA000, 1);
    add("only_self",    4'b0001, 0, 0, 8, 2'd0, 1, 16'hA000, 1);
    add("pre_hold",     4'b1111, 0, 0, 3, 2'd0, 1, 16'hA000, 0);
    add("hold20",       4'b1111, 1, 0, 20, 2'd0, 1, 16'hA000, 0);
    add("hold_next",    4'b1111, 1, 1, 1, 2'd1, 1, 16'hA001, 1);
    add("after_next7",  4'b1111, 0, 0, 7, 2'd1, 1, 16'hA001, 0);
    add("after_next8",  4'b1111, 0, 0, 1, 2'd2, 1, 16'hA002, 1);
    add("empty_mask",   4'b0000, 0, 0, 5, 2'd2, 0, 16'h0000, 0);
    add("empty_next",   4'b0000, 0, 1, 3, 2'd2, 0, 16'h0000, 0);
    add("restore0010",  4'b0010, 0, 0, 1, 2'd1, 1, 16'hA001, 1);
    add("pre_term",     4'b1111, 0, 0, 7, 2'd1, 1, 16'hA001, 0);
    add("term_next",    4'b1111, 0, 1, 1, 2'd2, 1, 16'hA002, 1);
    add("term_after",   4'b1111, 0, 0, 1, 2'd2, 1, 16'hA002, 0);
    add("hold_at_term", 4'b1111, 0, 0, 6, 2'd2, 1, 16'hA002, 0);
    add("hold_term10",  4'b1111, 1, 0, 10, 2'd2, 1, 16'hA002, 0);
    add("unhold_term",  4'b1111, 0, 0, 1, 2'd3, 1, 16'hA003, 1);
    add("next_held3",   4'b1111, 0, 1, 3, 2'd2, 1, 16'hA002, 3);
    add("cnt5_on2",     4'b1111, 0, 0, 5, 2'd2, 1, 16'hA002, 0);

    data_in = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    ch_en   = 4'b1111;
    hold    = 1'b0;
    next    = 1'b0;
`ifdef SCAN_FORCE_SEL_EN
    force_en  = 1'b0;
    force_idx = 2'd0;
`endif
    reset_n = 1'b0;
    #1;
    chk("reset.idx", 32'(sel_idx), 32'd0);
    chk("reset.pulse", 32'(switch_pulse), 32'd0);
    chk("reset.data", 32'(data_out), 32'hA000);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    foreach (vt[i]) begin
      ch_en = vt[i].en;
      hold  = vt[i].hold;
      next  = vt[i].next;
      run(vt[i].cyc);
      expect_state(vt[i].name, vt[i].idx, vt[i].valid, vt[i].data, vt[i].npulse);
    end
    hold = 1'b0;
    next = 1'b0;

    // Asynchronous reset mid-dwell (count 5 on ch 2) takes effect without a clock edge.
    reset_n = 1'b0;
    #2;
    chk("midreset.idx", 32'(sel_idx), 32'd0);
    chk("midreset.data", 32'(data_out), 32'hA000);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run(7);
    expect_state("post_reset7", 2'd0, 1'b1, 16'hA000, 0);
    run(1);
    expect_state("post_reset8", 2'd1, 1'b1, 16'hA001, 1);

    // Reset with ch 0 disabled: ch 0 is shown first, then the forced move.
    ch_en   = 4'b0100;
    reset_n = 1'b0;
    #2;
    chk("rst_dis0.idx", 32'(sel_idx), 32'd0);
    chk("rst_dis0.data", 32'(data_out), 32'hA000);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run(1);
    expect_state("rst_dis0_move", 2'd2, 1'b1, 16'hA002, 1);

`ifdef SCAN_FORCE_SEL_EN
    ch_en     = 4'b1111;
    force_en  = 1'b1;
    force_idx = 2'd3;
    run(1);
    expect_state("force_on", 2'd3, 1'b1, 16'hA003, 1);
    run(30);
    expect_state("force_hold30", 2'd3, 1'b1, 16'hA003, 0);
    ch_en = 4'b0000;
    run(2);
    expect_state("force_empty", 2'd3, 1'b1, 16'hA003, 0);
    ch_en    = 4'b1111;
    force_en = 1'b0;
    run(7);
    expect_state("release7", 2'd3, 1'b1, 16'hA003, 0);
    run(1);
    expect_state("release8", 2'd0, 1'b1, 16'hA000, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
